pifo_io_port_mux: RTL and testbench

Multi-port front end for the banked PIFO SRAM tree.
- Accepts push/pop requests from NUM_PORT host ports with valid/ready handshakes.
- Steers each request to sub-tree bank tree_id % LEVEL, buffers it per bank and issues it to the SRAM top.
- Pop results come back tagged with the originating port and tree id, plus an empty flag. Backpressure replaces the old task-fail pulse.

---
 rtl/pifo_io_port_mux.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pifo_io_port_mux.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_io_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : pifo_io_port_mux
// Purpose  : Multi-port front end for the banked PIFO SRAM tree. Host ports
//            issue push/pop requests with valid/ready handshakes; each request
//            is steered to bank tree_id % LEVEL, queued per bank and issued to
//            the SRAM top as a registered one-cycle strobe. Pop results return
//            in order per bank, are tagged with {port, tree_id} and merged
//            round-robin onto a single registered response channel.
// Ports    : i_clk/i_rst        clock, synchronous active-high reset
//            i_req_*/o_req_ready host request channel (one lane per port)
//            o_push/o_pop/o_tree_id/o_push_data  per-bank issue strobes
//            i_task_fifo_full   per-bank issue stall
//            i_pop_valid/i_pop_data  per-bank pop results (all-ones = empty)
//            o_rsp_*            merged pop responses (no backpressure)
//            o_err              sticky protocol/overflow error
// Revision : 1.0 - initial release
// ============================================================================
module pifo_io_port_mux #(
    parameter int PTW      = 16,
    parameter int MTW      = 44,
    parameter int LEVEL    = 4,   // power of 2, >= 2
    parameter int TREE_NUM = 16,  // >= LEVEL
    parameter int NUM_PORT = 2,
    parameter int QDEPTH   = 4,   // power of 2, >= 2
    localparam int W       = MTW + PTW,
    localparam int TB      = $clog2(TREE_NUM),
    localparam int PB      = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_PORT-1:0]    i_req_valid,
    input  logic [NUM_PORT-1:0]    i_req_pop,
    input  logic [NUM_PORT*TB-1:0] i_req_tree_id,
    input  logic [NUM_PORT*W-1:0]  i_req_data,
    output logic [NUM_PORT-1:0]    o_req_ready,
    output logic [LEVEL-1:0]       o_push,
    output logic [LEVEL-1:0]       o_pop,
    output logic [LEVEL*TB-1:0]    o_tree_id,
    output logic [LEVEL*W-1:0]     o_push_data,
    input  logic [LEVEL-1:0]       i_task_fifo_full,
    input  logic [LEVEL-1:0]       i_pop_valid,
    input  logic [LEVEL*W-1:0]     i_pop_data,
    output logic                   o_rsp_valid,
    output logic [PB-1:0]          o_rsp_port,
    output logic [TB-1:0]          o_rsp_tree_id,
    output logic [W-1:0]           o_rsp_data,
    output logic                   o_rsp_empty,
    output logic                   o_err
);

    localparam int LB   = $clog2(LEVEL);
    localparam int QB   = $clog2(QDEPTH);
    localparam int TAGW = PB + TB;
    localparam int RSPW = PB + TB + W;
    localparam int QEW  = PB + 1 + TB + W;   // {port, pop, tree_id, data}

    localparam logic [QB:0] c_qdepth = (QB+1)'(QDEPTH);

    // Cross-bank signals
    logic [LEVEL-1:0]      w_acc;        // bank accepts its arbitration winner
    logic [LEVEL*PB-1:0]   w_win_flat;   // winning port per bank
    logic [LEVEL-1:0]      w_rf_nempty;  // response FIFO holds an entry
    logic [LEVEL*RSPW-1:0] w_rf_head;    // response FIFO heads
    logic [LEVEL-1:0]      w_rf_rd;      // one-hot response FIFO read grant
    logic [LEVEL-1:0]      w_bank_err;   // unsolicited result or overflow
    logic                  r_post_rst;   // high only in the cycle after reset

    // ------------------------------------------------------------------------
    // Per-bank request arbitration, request queue, issue, tags and responses
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < LEVEL; b++) begin : g_bank
        logic [NUM_PORT-1:0] w_cand;
        logic                w_win_vld;
        logic [PB-1:0]       w_win;
        logic [PB-1:0]       r_rr;

        logic [QEW-1:0]      r_q [QDEPTH];
        logic [QB:0]         r_q_wp, r_q_rp;
        logic                w_q_full, w_q_empty;
        logic [QEW-1:0]      w_new, w_head;
        logic [PB-1:0]       w_h_port;
        logic                w_h_pop;
        logic [TB-1:0]       w_h_tree;
        logic [W-1:0]        w_h_data;
        logic                w_issue, w_pop_iss;
        logic [QB:0]         r_cred;

        logic [TAGW-1:0]     r_tag [QDEPTH];
        logic [QB:0]         r_t_wp, r_t_rp;
        logic                w_t_empty, w_ret, w_unsol;

        logic [RSPW-1:0]     r_rf [QDEPTH];
        logic [QB:0]         r_rf_wp, r_rf_rp;
        logic                w_rf_full, w_rf_empty, w_rf_wr, w_ovf;

        logic                r_push, r_pop;
        logic [TB-1:0]       r_tree;
        logic [W-1:0]        r_pdata;

        always_comb begin
            w_cand = '0;
            for (int p = 0; p < NUM_PORT; p++) begin
                w_cand[p] = i_req_valid[p] &&
                            (i_req_tree_id[p*TB +: LB] == LB'(b));
            end
        end

        // Round-robin: first candidate at or after the pointer wins
        always_comb begin
            w_win_vld = 1'b0;
            w_win     = '0;
            for (int k = 0; k < NUM_PORT; k++) begin
                if (!w_win_vld && w_cand[(int'(r_rr) + k) % NUM_PORT]) begin
                    w_win_vld = 1'b1;
                    w_win     = PB'((int'(r_rr) + k) % NUM_PORT);
                end
            end
        end

        assign w_q_empty = (r_q_wp == r_q_rp);
        assign w_q_full  = ((r_q_wp - r_q_rp) == c_qdepth);
        assign w_acc[b]  = w_win_vld && !w_q_full;
        assign w_win_flat[b*PB +: PB] = w_win;

        assign w_new = {w_win, i_req_pop[w_win],
                        i_req_tree_id[int'(w_win)*TB +: TB],
                        i_req_data[int'(w_win)*W +: W]};

        assign w_head   = r_q[r_q_rp[QB-1:0]];
        assign w_h_port = w_head[QEW-1 -: PB];
        assign w_h_pop  = w_head[TB+W];
        assign w_h_tree = w_head[W +: TB];
        assign w_h_data = w_head[W-1:0];

        // Pops need a credit so outstanding results always fit downstream
        assign w_issue   = !w_q_empty && !i_task_fifo_full[b] &&
                           (!w_h_pop || (r_cred != '0));
        assign w_pop_iss = w_issue && w_h_pop;

        assign w_t_empty = (r_t_wp == r_t_rp);
        assign w_ret     = i_pop_valid[b] && !w_t_empty && !r_post_rst;
        assign w_unsol   = i_pop_valid[b] &&  w_t_empty && !r_post_rst;

        assign w_rf_empty = (r_rf_wp == r_rf_rp);
        assign w_rf_full  = ((r_rf_wp - r_rf_rp) == c_qdepth);
        assign w_rf_wr    = w_ret && (!w_rf_full || w_rf_rd[b]);
        assign w_ovf      = w_ret &&   w_rf_full && !w_rf_rd[b];

        assign w_rf_nempty[b]             = !w_rf_empty;
        assign w_rf_head[b*RSPW +: RSPW]  = r_rf[r_rf_rp[QB-1:0]];
        assign w_bank_err[b]              = w_unsol || w_ovf;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rr    <= '0;
                r_q_wp  <= '0;
                r_q_rp  <= '0;
                r_t_wp  <= '0;
                r_t_rp  <= '0;
                r_rf_wp <= '0;
                r_rf_rp <= '0;
                r_cred  <= c_qdepth;
                r_push  <= 1'b0;
                r_pop   <= 1'b0;
                r_tree  <= '0;
                r_pdata <= '0;
            end else begin
                if (w_acc[b]) begin
                    r_q[r_q_wp[QB-1:0]] <= w_new;
                    r_q_wp <= r_q_wp + 1'b1;
                    r_rr   <= (int'(w_win) == NUM_PORT - 1) ? '0 : w_win + 1'b1;
                end
                if (w_issue) begin
                    r_q_rp <= r_q_rp + 1'b1;
                end

                r_push  <= w_issue && !w_h_pop;
                r_pop   <= w_pop_iss;
                r_tree  <= w_issue ? w_h_tree : '0;
                r_pdata <= (w_issue && !w_h_pop) ? w_h_data : '0;

                if (w_pop_iss) begin
                    r_tag[r_t_wp[QB-1:0]] <= {w_h_port, w_h_tree};
                    r_t_wp <= r_t_wp + 1'b1;
                end
                if (w_ret) begin
                    r_t_rp <= r_t_rp + 1'b1;
                end

                if (w_pop_iss && !w_ret) begin
                    r_cred <= r_cred - 1'b1;
                end else if (!w_pop_iss && w_ret) begin
                    r_cred <= r_cred + 1'b1;
                end

                if (w_rf_wr) begin
                    r_rf[r_rf_wp[QB-1:0]] <= {r_tag[r_t_rp[QB-1:0]], i_pop_data[b*W +: W]};
                    r_rf_wp <= r_rf_wp + 1'b1;
                end
                if (w_rf_rd[b]) begin
                    r_rf_rp <= r_rf_rp + 1'b1;
                end
            end
        end

        assign o_push[b]               = r_push;
        assign o_pop[b]                = r_pop;
        assign o_tree_id[b*TB +: TB]   = r_tree;
        assign o_push_data[b*W +: W]   = r_pdata;
    end

    // ------------------------------------------------------------------------
    // Request ready: a port is ready when its bank accepted it as the winner
    // ------------------------------------------------------------------------
    always_comb begin
        o_req_ready = '0;
        for (int b = 0; b < LEVEL; b++) begin
            for (int p = 0; p < NUM_PORT; p++) begin
                if (w_acc[b] && (int'(w_win_flat[b*PB +: PB]) == p)) begin
                    o_req_ready[p] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response merge: round-robin over non-empty bank response FIFOs
    // ------------------------------------------------------------------------
    logic [LB-1:0]   r_rsp_rr;
    logic [LB-1:0]   w_rsp_sel;
    logic            w_rsp_any;
    logic [RSPW-1:0] w_rsp_ent;

    always_comb begin
        w_rsp_any = 1'b0;
        w_rsp_sel = '0;
        for (int k = 0; k < LEVEL; k++) begin
            // LB-bit truncation wraps the index since LEVEL is a power of 2
            if (!w_rsp_any && w_rf_nempty[LB'(int'(r_rsp_rr) + k)]) begin
                w_rsp_any = 1'b1;
                w_rsp_sel = LB'(int'(r_rsp_rr) + k);
            end
        end
    end

    assign w_rf_rd   = w_rsp_any ? (LEVEL'(1) << w_rsp_sel) : '0;
    assign w_rsp_ent = w_rf_head[int'(w_rsp_sel)*RSPW +: RSPW];

    logic          r_rsp_valid;
    logic [PB-1:0] r_rsp_port;
    logic [TB-1:0] r_rsp_tree;
    logic [W-1:0]  r_rsp_data;
    logic          r_rsp_empty;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_rr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= '0;
            r_rsp_tree  <= '0;
            r_rsp_data  <= '0;
            r_rsp_empty <= 1'b0;
            r_err       <= 1'b0;
            r_post_rst  <= 1'b1;
        end else begin
            r_post_rst  <= 1'b0;
            r_err       <= r_err | (|w_bank_err);
            r_rsp_valid <= w_rsp_any;
            if (w_rsp_any) begin
                r_rsp_rr    <= w_rsp_sel + 1'b1;
                r_rsp_port  <= w_rsp_ent[RSPW-1 -: PB];
                r_rsp_tree  <= w_rsp_ent[W +: TB];
                r_rsp_data  <= w_rsp_ent[W-1:0];
                r_rsp_empty <= &w_rsp_ent[W-1:0];
            end else begin
                r_rsp_port  <= '0;
                r_rsp_tree  <= '0;
                r_rsp_data  <= '0;
                r_rsp_empty <= 1'b0;
            end
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_port    = r_rsp_port;
    assign o_rsp_tree_id = r_rsp_tree;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_empty   = r_rsp_empty;
    assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pifo_io_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_io_port_mux
// Purpose  : Self-checking bench for pifo_io_port_mux (default parameters).
//            Table of single-request vectors plus directed multi-cycle
//            sequences for stalls, credits, response merging and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_io_port_mux;

    localparam int W = 60;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_pop;
    logic [7:0]    req_tree_id;
    logic [119:0]  req_data;
    logic [1:0]    req_ready;
    logic [3:0]    push;
    logic [3:0]    pop;
    logic [15:0]   tree_id;
    logic [239:0]  push_data;
    logic [3:0]    task_full;
    logic [3:0]    pop_valid;
    logic [239:0]  pop_data;
    logic          rsp_valid;
    logic [0:0]    rsp_port;
    logic [3:0]    rsp_tree;
    logic [59:0]   rsp_data;
    logic          rsp_empty;
    logic          err;

    pifo_io_port_mux dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_pop        (req_pop),
        .i_req_tree_id    (req_tree_id),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_push           (push),
        .o_pop            (pop),
        .o_tree_id        (tree_id),
        .o_push_data      (push_data),
        .i_task_fifo_full (task_full),
        .i_pop_valid      (pop_valid),
        .i_pop_data       (pop_data),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_port       (rsp_port),
        .o_rsp_tree_id    (rsp_tree),
        .o_rsp_data       (rsp_data),
        .o_rsp_empty      (rsp_empty),
        .o_err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req_valid = '0;
        req_pop   = '0;
        pop_valid = '0;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  tree0;
        logic [3:0]  tree1;
        logic [1:0]  exp_ready;
        logic [3:0]  exp_push;
        logic [15:0] exp_tree;
    } vec_t;

    vec_t vecs [9];
    int   pop_cnt;

    initial begin
        // Push-only vectors; RR pointers tracked by hand across the table
        vecs[0] = '{2'b11, 4'd2,  4'd2,  2'b01, 4'b0100, 16'h0200};
        vecs[1] = '{2'b11, 4'd2,  4'd2,  2'b10, 4'b0100, 16'h0200};
        vecs[2] = '{2'b11, 4'd2,  4'd2,  2'b01, 4'b0100, 16'h0200};
        vecs[3] = '{2'b11, 4'd0,  4'd1,  2'b11, 4'b0011, 16'h0010};
        vecs[4] = '{2'b11, 4'd7,  4'd9,  2'b11, 4'b1010, 16'h7090};
        vecs[5] = '{2'b10, 4'd0,  4'd14, 2'b10, 4'b0100, 16'h0E00};
        vecs[6] = '{2'b11, 4'd13, 4'd13, 2'b01, 4'b0010, 16'h00D0};
        vecs[7] = '{2'b00, 4'd0,  4'd0,  2'b00, 4'b0000, 16'h0000};
        vecs[8] = '{2'b11, 4'd12, 4'd4,  2'b10, 4'b0001, 16'h0004};

        rst = 1'b1; idle(); req_tree_id = '0; req_data = '0;
        task_full = '0; pop_data = '0;
        step; step;
        rst = 1'b0;

        // ---- reset state ----
        check("rst_push",  64'(push), 64'h0);
        check("rst_pop",   64'(pop), 64'h0);
        check("rst_tree",  64'(tree_id), 64'h0);
        check("rst_rspv",  64'(rsp_valid), 64'h0);
        check("rst_err",   64'(err), 64'h0);
        check("rst_ready", 64'(req_ready), 64'h0);

        // ---- port0 push tree 5 -> bank 1 ----
        req_valid = 2'b01; req_tree_id = {4'd0, 4'd5}; req_data = {60'h0, 60'h1};
        #1 check("t1_ready", 64'(req_ready), 64'h1);
        step; idle();
        check("t1_no_early_strobe", 64'(push), 64'h0);
        step;
        check("t1_push",  64'(push), 64'h2);
        check("t1_pop",   64'(pop), 64'h0);
        check("t1_tree",  64'(tree_id[7:4]), 64'h5);
        check("t1_pdata", 64'(push_data[119:60]), 64'h1);
        step;
        check("t1_strobe_clear", 64'(push), 64'h0);

        // ---- table vectors ----
        for (int i = 0; i < 9; i++) begin
            req_valid   = vecs[i].valid;
            req_pop     = 2'b00;
            req_tree_id = {vecs[i].tree1, vecs[i].tree0};
            req_data    = {60'(32'h200 + i), 60'(32'h100 + i)};
            #1 check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            step; idle();
            step;
            check($sformatf("vec%0d_push", i), 64'(push), 64'(vecs[i].exp_push));
            check($sformatf("vec%0d_tree", i), 64'(tree_id), 64'(vecs[i].exp_tree));
            check($sformatf("vec%0d_pop", i), 64'(pop), 64'h0);
            step;
        end

        // ---- bank 3 stalled: 4 accepted, 5th blocked, bank 0 unaffected ----
        task_full = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            req_valid   = 2'b11;
            req_tree_id = {4'd0, 4'd3};
            req_data    = {60'(32'h500 + i), 60'(32'h30 + i)};
            #1;
            check($sformatf("stall_rdy0_%0d", i), 64'(req_ready[0]), 64'(i < 4));
            check($sformatf("stall_rdy1_%0d", i), 64'(req_ready[1]), 64'h1);
            step;
        end
        req_valid = 2'b01;
        #1;
        check("stall_b3_quiet", 64'(push[3]), 64'h0);
        check("stall_b0_flows", 64'(push[0]), 64'h1);
        task_full = 4'b0000;
        #1 check("stall_rdy_release", 64'(req_ready[0]), 64'h0);
        for (int j = 0; j < 5; j++) begin
            step;
            if (j == 0) check("stall_rdy_after", 64'(req_ready[0]), 64'h1);
            if (j == 1) req_valid = 2'b00;
            check($sformatf("drain_push_%0d", j), 64'(push[3]), 64'h1);
            check($sformatf("drain_data_%0d", j), 64'(push_data[239:180]), 64'(32'h30 + j));
        end
        step;
        check("drain_done", 64'(push[3]), 64'h0);

        // ---- pop tree 6 (bank 2) from port 1 ----
        req_valid = 2'b10; req_pop = 2'b10; req_tree_id = {4'd6, 4'd0};
        #1 check("pop_ready", 64'(req_ready), 64'h2);
        step; idle();
        step;
        check("pop_strobe", 64'(pop), 64'h4);
        check("pop_tree",   64'(tree_id[11:8]), 64'h6);
        check("pop_pdata0", 64'(push_data[179:120]), 64'h0);
        step; step;
        pop_valid = 4'b0100; pop_data[179:120] = 60'hABC;
        step; pop_valid = '0;
        check("rsp_not_yet", 64'(rsp_valid), 64'h0);
        step;
        check("rsp_valid", 64'(rsp_valid), 64'h1);
        check("rsp_port",  64'(rsp_port), 64'h1);
        check("rsp_tree",  64'(rsp_tree), 64'h6);
        check("rsp_data",  64'(rsp_data), 64'hABC);
        check("rsp_empty", 64'(rsp_empty), 64'h0);
        step;
        check("rsp_single", 64'(rsp_valid), 64'h0);

        // ---- empty tree result ----
        req_valid = 2'b01; req_pop = 2'b01; req_tree_id = {4'd0, 4'd10};
        step; idle();
        step;
        check("pop2_strobe", 64'(pop), 64'h4);
        pop_valid = 4'b0100; pop_data[179:120] = '1;
        step; pop_valid = '0;
        step;
        check("rsp2_valid", 64'(rsp_valid), 64'h1);
        check("rsp2_port",  64'(rsp_port), 64'h0);
        check("rsp2_tree",  64'(rsp_tree), 64'hA);
        check("rsp2_data",  64'(rsp_data), 64'h0FFF_FFFF_FFFF_FFFF);
        check("rsp2_empty", 64'(rsp_empty), 64'h1);
        step;

        // ---- credit limit: 5 pops to bank 0, only 4 issue ----
        pop_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 2'b01; req_pop = 2'b01;
            req_tree_id = {4'd0, 4'(4 * (i % 4))};
            #1 check($sformatf("cred_rdy_%0d", i), 64'(req_ready[0]), 64'h1);
            step;
            pop_cnt += int'(pop[0]);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            step;
            pop_cnt += int'(pop[0]);
        end
        check("cred_limit", 64'(pop_cnt), 64'd4);
        pop_valid = 4'b0001; pop_data[59:0] = 60'h111;
        step; pop_valid = '0;
        check("cred_wait", 64'(pop[0]), 64'h0);
        step;
        check("cred_5th_pop",  64'(pop[0]), 64'h1);
        check("cred_5th_tree", 64'(tree_id[3:0]), 64'h0);
        check("cred_rsp_data", 64'(rsp_data), 64'h111);
        check("cred_rsp_tree", 64'(rsp_tree), 64'h0);
        step;

        // ---- simultaneous results on banks 0 and 1 ----
        req_valid = 2'b10; req_pop = 2'b10; req_tree_id = {4'd1, 4'd0};
        #1 check("b1_ready", 64'(req_ready), 64'h2);
        step; idle();
        step;
        check("b1_pop", 64'(pop), 64'h2);
        pop_valid = 4'b0011; pop_data[59:0] = 60'h222; pop_data[119:60] = 60'h333;
        step; pop_valid = '0;
        step;
        check("rr_first_valid", 64'(rsp_valid), 64'h1);
        check("rr_first_port",  64'(rsp_port), 64'h1);
        check("rr_first_tree",  64'(rsp_tree), 64'h1);
        check("rr_first_data",  64'(rsp_data), 64'h333);
        step;
        check("rr_second_valid", 64'(rsp_valid), 64'h1);
        check("rr_second_port",  64'(rsp_port), 64'h0);
        check("rr_second_tree",  64'(rsp_tree), 64'h4);
        check("rr_second_data",  64'(rsp_data), 64'h222);
        step;
        check("rr_done", 64'(rsp_valid), 64'h0);

        // ---- unsolicited result -> sticky error ----
        check("err_clear", 64'(err), 64'h0);
        pop_valid = 4'b0100;
        step; pop_valid = '0;
        check("err_set", 64'(err), 64'h1);
        check("err_no_rsp", 64'(rsp_valid), 64'h0);
        step; step;
        check("err_sticky", 64'(err), 64'h1);

        // ---- reset mid-traffic ----
        req_valid = 2'b11; req_pop = 2'b10; req_tree_id = {4'd5, 4'd3};
        req_data = {60'h0, 60'h77};
        #1 check("mrst_ready", 64'(req_ready), 64'h3);
        step; idle();
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("mrst_push",  64'(push), 64'h0);
        check("mrst_pop",   64'(pop), 64'h0);
        check("mrst_tree",  64'(tree_id), 64'h0);
        check("mrst_pdata", 64'(push_data[63:0]), 64'h0);
        check("mrst_err",   64'(err), 64'h0);
        pop_valid = 4'b0001;
        step; pop_valid = '0;
        check("post_rst_err",  64'(err), 64'h0);
        check("post_rst_rspv", 64'(rsp_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step;
            check($sformatf("post_rst_quiet_%0d", i), 64'({push, pop, rsp_valid}), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
